// File: rtl/fibonacci_checker.sv
// fibonacci_checker: tracks a Fibonacci stream with overflow restart, flags mismatches and counts matches/errors
module fibonacci_checker #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] fib_in,
    output logic             locked,
    output logic             err,
    output logic [WIDTH-1:0] expected,
    output logic [CNT_W-1:0] match_cnt,
    output logic [CNT_W-1:0] err_cnt
);
    typedef enum logic [1:0] {HUNT, PRIME, TRACK} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] p_q, p_d, c_q, c_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] match_q, match_d, errc_q, errc_d;
    logic [WIDTH:0]   s;

    always_comb begin
        s       = {1'b0, p_q} + {1'b0, c_q};
        state_d = state_q;
        p_d     = p_q;
        c_d     = c_q;
        err_d   = 1'b0;
        match_d = match_q;
        errc_d  = errc_q;
        if (in_valid) begin
            case (state_q)
                HUNT: begin
                    if (fib_in == '0) begin
                        state_d = TRACK;
                        p_d     = '0;
                        c_d     = WIDTH'(1);
                    end else if (fib_in == WIDTH'(1)) begin
                        state_d = PRIME;
                        p_d     = WIDTH'(1);
                        c_d     = WIDTH'(1);
                    end
                end
                PRIME: begin
                    state_d = (fib_in <= WIDTH'(2)) ? TRACK : HUNT;
                    p_d     = (fib_in == WIDTH'(2)) ? WIDTH'(2) : (fib_in == WIDTH'(1)) ? WIDTH'(1) : '0;
                    c_d     = (fib_in == WIDTH'(2)) ? WIDTH'(3) : (fib_in == WIDTH'(1)) ? WIDTH'(2) : WIDTH'(1);
                end
                TRACK: begin
                    if (fib_in == c_q) begin
                        // carry out of p+c means the generator restarted at (0,1)
                        p_d     = s[WIDTH] ? '0 : c_q;
                        c_d     = s[WIDTH] ? WIDTH'(1) : s[WIDTH-1:0];
                        match_d = (match_q == '1) ? match_q : match_q + CNT_W'(1);
                    end else begin
                        err_d   = 1'b1;
                        errc_d  = (errc_q == '1) ? errc_q : errc_q + CNT_W'(1);
                        state_d = (fib_in == '0) ? TRACK : HUNT;
                        p_d     = '0;
                        c_d     = WIDTH'(1);
                    end
                end
                default: state_d = HUNT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= HUNT;
            p_q     <= '0;
            c_q     <= '0;
            err_q   <= 1'b0;
            match_q <= '0;
            errc_q  <= '0;
        end else begin
            state_q <= state_d;
            p_q     <= p_d;
            c_q     <= c_d;
            err_q   <= err_d;
            match_q <= match_d;
            errc_q  <= errc_d;
        end
    end

    assign locked    = (state_q == TRACK);
    assign err       = err_q;
    assign expected  = (state_q == TRACK) ? c_q : '0;
    assign match_cnt = match_q;
    assign err_cnt   = errc_q;
endmodule

// File: tb/tb_fibonacci_checker.sv
// tb_fibonacci_checker: directed scenarios for fibonacci_checker with hand-computed expectations
module tb_fibonacci_checker;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       in_valid = 1'b0;
    logic [3:0] fib_in = '0;
    logic       locked, err, locked2, err2;
    logic [3:0] expected, expected2;
    logic [7:0] match_cnt, err_cnt;
    logic [1:0] match_cnt2, err_cnt2;
    int         errors = 0;
    int         checks = 0;

    always #5 clk = ~clk;

    fibonacci_checker #(.WIDTH(4), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .fib_in(fib_in),
        .locked(locked), .err(err), .expected(expected),
        .match_cnt(match_cnt), .err_cnt(err_cnt)
    );

    fibonacci_checker #(.WIDTH(4), .CNT_W(2)) dut2 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .fib_in(fib_in),
        .locked(locked2), .err(err2), .expected(expected2),
        .match_cnt(match_cnt2), .err_cnt(err_cnt2)
    );

    task automatic step(input logic v, input logic [3:0] x);
        in_valid = v;
        fib_in   = x;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({locked, err, expected, match_cnt, err_cnt} !== 22'd0) begin
            errors++;
            $display("FAIL reset: got locked=%0b err=%0b exp=%0d mc=%0d ec=%0d want all 0",
                     locked, err, expected, match_cnt, err_cnt);
        end
    endtask

    task automatic test_lock_stream();
        logic [3:0] seq [8] = '{4'd0, 4'd1, 4'd1, 4'd2, 4'd3, 4'd5, 4'd8, 4'd13};
        logic [3:0] nxt [8] = '{4'd1, 4'd1, 4'd2, 4'd3, 4'd5, 4'd8, 4'd13, 4'd1};
        do_reset();
        for (int i = 0; i < 8; i++) begin
            step(1'b1, seq[i]);
            checks++;
            if (locked !== 1'b1 || err !== 1'b0 || expected !== nxt[i]) begin
                errors++;
                $display("FAIL lock_stream[%0d]: got locked=%0b err=%0b exp=%0d want 1 0 %0d",
                         i, locked, err, expected, nxt[i]);
            end
        end
        checks++;
        if (match_cnt !== 8'd7) begin
            errors++;
            $display("FAIL lock_match_cnt: got %0d want 7", match_cnt);
        end
    endtask

    task automatic test_wrap();
        logic [3:0] seq [3] = '{4'd1, 4'd1, 4'd2};
        for (int i = 0; i < 3; i++) begin
            step(1'b1, seq[i]);
            checks++;
            if (err !== 1'b0 || locked !== 1'b1) begin
                errors++;
                $display("FAIL wrap[%0d]: got err=%0b locked=%0b want 0 1", i, err, locked);
            end
        end
        checks++;
        if (match_cnt !== 8'd10 || expected !== 4'd3 || err_cnt !== 8'd0) begin
            errors++;
            $display("FAIL wrap_final: got mc=%0d exp=%0d ec=%0d want 10 3 0", match_cnt, expected, err_cnt);
        end
    endtask

    task automatic test_mismatch_relock();
        do_reset();
        step(1'b1, 4'd0);
        step(1'b1, 4'd1);
        step(1'b1, 4'd1);
        step(1'b1, 4'd2);
        step(1'b1, 4'd5);
        checks++;
        if (err !== 1'b1 || err_cnt !== 8'd1 || locked !== 1'b0 || expected !== 4'd0) begin
            errors++;
            $display("FAIL mismatch: got err=%0b ec=%0d locked=%0b exp=%0d want 1 1 0 0",
                     err, err_cnt, locked, expected);
        end
        step(1'b0, 4'd0);
        checks++;
        if (err !== 1'b0 || err_cnt !== 8'd1) begin
            errors++;
            $display("FAIL mismatch_pulse: got err=%0b ec=%0d want 0 1", err, err_cnt);
        end
        step(1'b1, 4'd0);
        step(1'b1, 4'd1);
        step(1'b1, 4'd1);
        checks++;
        if (locked !== 1'b1 || match_cnt !== 8'd5 || expected !== 4'd2 || err !== 1'b0) begin
            errors++;
            $display("FAIL relock: got locked=%0b mc=%0d exp=%0d err=%0b want 1 5 2 0",
                     locked, match_cnt, expected, err);
        end
    endtask

    task automatic test_prime();
        do_reset();
        step(1'b1, 4'd1);
        checks++;
        if (locked !== 1'b0 || expected !== 4'd0) begin
            errors++;
            $display("FAIL prime_hold: got locked=%0b exp=%0d want 0 0", locked, expected);
        end
        step(1'b1, 4'd2);
        checks++;
        if (locked !== 1'b1 || expected !== 4'd3 || match_cnt !== 8'd0) begin
            errors++;
            $display("FAIL prime_lock: got locked=%0b exp=%0d mc=%0d want 1 3 0", locked, expected, match_cnt);
        end
        step(1'b1, 4'd3);
        step(1'b1, 4'd5);
        checks++;
        if (match_cnt !== 8'd2 || expected !== 4'd8 || err_cnt !== 8'd0 || err !== 1'b0) begin
            errors++;
            $display("FAIL prime_track: got mc=%0d exp=%0d ec=%0d err=%0b want 2 8 0 0",
                     match_cnt, expected, err_cnt, err);
        end
    endtask

    task automatic test_inject_zero_gaps();
        do_reset();
        step(1'b1, 4'd0);
        step(1'b1, 4'd1);
        step(1'b1, 4'd1);
        step(1'b1, 4'd0);
        checks++;
        if (err !== 1'b1 || err_cnt !== 8'd1 || locked !== 1'b1 || expected !== 4'd1) begin
            errors++;
            $display("FAIL inject0: got err=%0b ec=%0d locked=%0b exp=%0d want 1 1 1 1",
                     err, err_cnt, locked, expected);
        end
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 4'd9);
            checks++;
            if (err !== 1'b0 || err_cnt !== 8'd1 || locked !== 1'b1 || expected !== 4'd1 || match_cnt !== 8'd2) begin
                errors++;
                $display("FAIL gap[%0d]: got err=%0b ec=%0d locked=%0b exp=%0d mc=%0d want 0 1 1 1 2",
                         i, err, err_cnt, locked, expected, match_cnt);
            end
        end
        step(1'b1, 4'd1);
        step(1'b0, 4'd7);
        step(1'b1, 4'd1);
        checks++;
        if (match_cnt !== 8'd4 || expected !== 4'd2 || err !== 1'b0) begin
            errors++;
            $display("FAIL gap_resume: got mc=%0d exp=%0d err=%0b want 4 2 0", match_cnt, expected, err);
        end
    endtask

    task automatic test_saturate_reset();
        logic [1:0] want [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        do_reset();
        step(1'b1, 4'd0);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 4'd0);
            checks++;
            if (err_cnt2 !== want[i] || err2 !== 1'b1 || locked2 !== 1'b1) begin
                errors++;
                $display("FAIL sat[%0d]: got ec=%0d err=%0b locked=%0b want %0d 1 1",
                         i, err_cnt2, err2, locked2, want[i]);
            end
        end
        reset = 1'b1;
        step(1'b1, 4'd1);
        reset = 1'b0;
        checks++;
        if ({locked2, err2, expected2, match_cnt2, err_cnt2} !== 10'd0) begin
            errors++;
            $display("FAIL midreset: got locked=%0b err=%0b exp=%0d mc=%0d ec=%0d want all 0",
                     locked2, err2, expected2, match_cnt2, err_cnt2);
        end
    endtask

    initial begin
        test_reset();
        test_lock_stream();
        test_wrap();
        test_mismatch_relock();
        test_prime();
        test_inject_zero_gaps();
        test_saturate_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
